ysyx_22050243_lsu: RTL

Multi-cycle load/store unit for the RV64 NPC core, sitting between execute and write-back. It consumes the memory control fields produced by instruction decode:
- `mem_r`, `mem_w`, `funct3`;
- the ALU-computed effective address and the store data.

It issues one aligned 64-bit request on a valid/ready data-memory port, then returns sign- or zero-extended load data (or a store acknowledge) to write-back. It is the consuming end of the decoder's memory-control outputs and the initiator toward data memory.

---
 rtl/ysyx_22050243_pkg.sv | 36 +++
 rtl/ysyx_22050243_lsu_ext.sv | 36 +++
 rtl/ysyx_22050243_lsu.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ysyx_22050243_pkg.sv
// ============================================================================
// ysyx_22050243_pkg : shared funct3 size codes and LSU state encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package ysyx_22050243_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_D  = 3'b011;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;
    localparam logic [2:0] LSU_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // Byte-enable pattern for a 2^size_lg byte access at lane 0.
    function automatic logic [7:0] lsu_lane_mask(input logic [1:0] size_lg);
        case (size_lg)
            2'd0:    lsu_lane_mask = 8'h01;
            2'd1:    lsu_lane_mask = 8'h03;
            2'd2:    lsu_lane_mask = 8'h0F;
            default: lsu_lane_mask = 8'hFF;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22050243_lsu_ext.sv
// ============================================================================
// ysyx_22050243_lsu_ext : combinational load-lane extraction and extension
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22050243_lsu_ext
    import ysyx_22050243_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      off_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] ext_o
);

    logic [XLEN-1:0] w_shifted;
    logic            w_signed;

    assign w_shifted = rdata_i >> {off_i, 3'b000};
    assign w_signed  = ~funct3_i[2];

    always_comb begin
        ext_o = '0;
        case (funct3_i[1:0])
            2'd0:    ext_o = {{(XLEN-8){w_signed & w_shifted[7]}},   w_shifted[7:0]};
            2'd1:    ext_o = {{(XLEN-16){w_signed & w_shifted[15]}}, w_shifted[15:0]};
            2'd2:    ext_o = {{(XLEN-32){w_signed & w_shifted[31]}}, w_shifted[31:0]};
            default: ext_o = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_22050243_lsu.sv
// ============================================================================
// ysyx_22050243_lsu : multi-cycle load/store unit, one aligned 64-bit request
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22050243_lsu
    import ysyx_22050243_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int MASK_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mem_r,
    input  logic              in_mem_w,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rdata,
    output logic              out_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata
);

    lsu_state_t        state_q;
    logic [2:0]        off_q;
    logic [2:0]        funct3_q;
    logic              we_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;

    logic [2:0]        w_off;
    logic [2:0]        w_align_mask;
    logic              w_misaligned;
    logic              w_illegal;
    logic              w_is_mem;
    logic              w_err;
    logic [MASK_W-1:0] w_wmask;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_ext;

    assign w_off = in_addr[2:0];

    always_comb begin
        w_align_mask = 3'b000;
        case (in_funct3[1:0])
            2'd0:    w_align_mask = 3'b000;
            2'd1:    w_align_mask = 3'b001;
            2'd2:    w_align_mask = 3'b011;
            default: w_align_mask = 3'b111;
        endcase
    end

    assign w_misaligned = |(w_off & w_align_mask);
    assign w_illegal    = (in_mem_r & in_mem_w)
                        | (in_mem_r & (in_funct3 == 3'b111))
                        | (in_mem_w & in_funct3[2]);
    assign w_is_mem     = in_mem_r | in_mem_w;
    // Misalignment only matters for real memory ops; plain ALU ops pass through cleanly.
    assign w_err        = w_is_mem & (w_illegal | w_misaligned);
    assign w_wmask      = MASK_W'(lsu_lane_mask(in_funct3[1:0])) << w_off;
    assign w_wdata      = in_wdata << {w_off, 3'b000};

    ysyx_22050243_lsu_ext #(
        .XLEN(XLEN)
    ) u_ext (
        .rdata_i  (mem_resp_rdata),
        .off_i    (off_q),
        .funct3_i (funct3_q),
        .ext_o    (w_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            off_q    <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        off_q    <= w_off;
                        funct3_q <= in_funct3;
                        rdata_q  <= '0;
                        err_q    <= w_err;
                        if (w_is_mem && !w_err) begin
                            state_q <= ST_REQ;
                            we_q    <= in_mem_w;
                            addr_q  <= {in_addr[XLEN-1:3], 3'b000};
                            wmask_q <= in_mem_w ? w_wmask : '0;
                            wdata_q <= in_mem_w ? w_wdata : '0;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        rdata_q <= we_q ? '0 : w_ext;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign mem_req_valid = (state_q == ST_REQ);
    assign out_valid     = (state_q == ST_DONE);
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
    assign out_rdata     = rdata_q;
    assign out_err       = err_q;

endmodule

`default_nettype wire
